// File: rtl/prog_run_ctrl_if.sv
// Bench/PC-side bundle for the run controller: Start/Done handshake, PC hold/load
// controls and run status.
interface prog_run_ctrl_if #(
  parameter int A  = 10,
  parameter int CW = 16
);
  logic          Start;
  logic          Halt;
  logic [A-1:0]  ProgCtr;
  logic          PcHold;
  logic          PcLoadEn;
  logic [A-1:0]  PcLoadVal;
  logic          Done;
  logic          Timeout;
  logic          Fault;
  logic [1:0]    ProgIdx;
  logic [CW-1:0] CycleCount;

  modport slave (
    input  Start, Halt, ProgCtr,
    output PcHold, PcLoadEn, PcLoadVal, Done, Timeout, Fault, ProgIdx, CycleCount
  );

  modport master (
    output Start, Halt, ProgCtr,
    input  PcHold, PcLoadEn, PcLoadVal, Done, Timeout, Fault, ProgIdx, CycleCount
  );
endinterface

// File: rtl/prog_run_ctrl.sv
// Run controller: launches the next program on a Start falling edge, loads the PC
// with its base, lets it run, and freezes it on halt, out-of-range fetch or watchdog.
module prog_run_ctrl #(
  parameter int A           = 10,
  parameter int NUM_PROGS   = 3,
  parameter int PROG_STRIDE = 100,
  parameter int CW          = 16,
  parameter int MAX_CYCLES  = 4096
) (
  input  logic            Clk,
  input  logic            Reset,
  prog_run_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ARMED, LOAD, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic          start_q;
  logic [1:0]    idx_q, idx_d;
  logic [A-1:0]  base_q, base_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          to_q, to_d;
  logic          flt_q, flt_d;

  logic          rise, fall, in_range;
  logic [1:0]    idx_inc;
  logic [A-1:0]  base_inc;
  logic [A:0]    base_hi;

  assign rise = bus.Start & ~start_q;
  assign fall = ~bus.Start & start_q;

  // Program numbers run 1..NUM_PROGS; 0 only exists before the first launch.
  assign idx_inc  = (idx_q >= 2'(NUM_PROGS)) ? 2'd1 : idx_q + 2'd1;
  assign base_inc = A'(32'(idx_inc - 2'd1) * 32'(PROG_STRIDE));

  // One extra bit so base+STRIDE-1 cannot wrap past the top of memory.
  assign base_hi  = {1'b0, base_q} + (A+1)'(PROG_STRIDE - 1);
  assign in_range = (bus.ProgCtr >= base_q) && ({1'b0, bus.ProgCtr} <= base_hi);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      idx_q   <= '0;
      base_q  <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.Start;
      idx_q   <= idx_d;
      base_q  <= base_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
      flt_q   <= flt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    flt_d   = flt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (rise) begin
          state_d = ARMED;
          idx_d   = idx_inc;
          base_d  = base_inc;
          cyc_d   = '0;
          to_d    = 1'b0;
          flt_d   = 1'b0;
        end
      end
      ARMED: if (fall) state_d = LOAD;
      LOAD:  state_d = RUN;
      RUN: begin
        // The exit cycle is itself a RUN cycle, so it is always counted.
        if (cyc_q != '1) cyc_d = cyc_q + CW'(1);
        if (bus.Halt) begin
          state_d = DONE;
        end else if (!in_range) begin
          state_d = DONE;
          flt_d   = 1'b1;
        end else if (cyc_q == CW'(MAX_CYCLES - 1)) begin
          state_d = DONE;
          to_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.PcHold     = (state_q != RUN);
  assign bus.PcLoadEn   = (state_q == LOAD);
  assign bus.PcLoadVal  = base_q;
  assign bus.Done       = (state_q == DONE);
  assign bus.Timeout    = to_q;
  assign bus.Fault      = flt_q;
  assign bus.ProgIdx    = idx_q;
  assign bus.CycleCount = cyc_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl: a per-cycle reference model checked every
// cycle, plus literal expectations at the key points of each launch.
module tb_prog_run_ctrl;
  localparam int A  = 10;
  localparam int CW = 16;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  prog_run_ctrl_if #(.A(A), .CW(CW)) bus ();

  prog_run_ctrl #(.A(A), .NUM_PROGS(3), .PROG_STRIDE(100), .CW(CW), .MAX_CYCLES(4096)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 waiting for Start to drop, 2 loading, 3 running, 4 finished.
  int m_ph = 0, m_prog = 0, m_cnt = 0, m_base = 0;
  bit m_prev = 0, m_to = 0, m_flt = 0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_ph = 0; m_prog = 0; m_cnt = 0; m_base = 0; m_prev = 0; m_to = 0; m_flt = 0;
    end else begin
      if ((m_ph == 0 || m_ph == 4) && bus.Start && !m_prev) begin
        m_prog = (m_prog % 3) + 1;
        m_base = (m_prog - 1) * 100;
        m_ph = 1; m_cnt = 0; m_to = 0; m_flt = 0;
      end else if (m_ph == 1 && !bus.Start && m_prev) begin
        m_ph = 2;
      end else if (m_ph == 2) begin
        m_ph = 3;
      end else if (m_ph == 3) begin
        if (m_cnt < 65535) m_cnt++;
        if (bus.Halt) m_ph = 4;
        else if (int'(bus.ProgCtr) < m_base || int'(bus.ProgCtr) > m_base + 99) begin
          m_ph = 4; m_flt = 1;
        end else if (m_cnt == 4096) begin
          m_ph = 4; m_to = 1;
        end
      end
      m_prev = bus.Start;
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      if (m_ph != 2) chk("PcHold", bus.PcHold, (m_ph != 3));
      chk("PcLoadEn",   bus.PcLoadEn,   (m_ph == 2));
      chk("PcLoadVal",  bus.PcLoadVal,  m_base);
      chk("Done",       bus.Done,       (m_ph == 4));
      chk("Timeout",    bus.Timeout,    m_to);
      chk("Fault",      bus.Fault,      m_flt);
      chk("ProgIdx",    bus.ProgIdx,    m_prog);
      chk("CycleCount", bus.CycleCount, m_cnt);
    end
  end

  task automatic launch(int hi);
    @(negedge Clk); #1;
    bus.Start = 1'b1;
    repeat (hi) @(negedge Clk);
    #1 bus.Start = 1'b0;
  endtask

  task automatic wait_load(int exp_val);
    bit seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge Clk); #1;
      if (bus.PcLoadEn) seen = 1'b1;
    end
    chk("load_seen", seen, 1);
    if (seen) chk("load_val", bus.PcLoadVal, exp_val);
  endtask

  // Drives n RUN cycles; the PC walks from the base, optionally forced on the last one.
  task automatic run(int base, int n, bit halt_last, int pc_last, bit tog);
    for (int i = 1; i <= n; i++) begin
      @(negedge Clk); #1;
      if (i == 1) begin
        chk("first_run_hold", bus.PcHold, 0);
        chk("first_run_noload", bus.PcLoadEn, 0);
      end
      bus.ProgCtr = A'(base + ((i - 1) % 100));
      if (i == n && pc_last >= 0) bus.ProgCtr = A'(pc_last);
      bus.Halt = halt_last && (i == n);
      if (tog) bus.Start = ((i % 4) < 2);
    end
    @(negedge Clk); #1;
    bus.Halt = 1'b0;
  endtask

  initial begin
    bus.Start = 1'b0; bus.Halt = 1'b0; bus.ProgCtr = '0;
    #1 Reset = 1'b1;
    repeat (2) @(negedge Clk); #1;
    chk("rst_hold", bus.PcHold, 1);
    chk("rst_load", bus.PcLoadEn, 0);
    chk("rst_val", bus.PcLoadVal, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_idx", bus.ProgIdx, 0);
    chk("rst_cnt", bus.CycleCount, 0);
    chk("rst_flags", {bus.Timeout, bus.Fault}, 0);
    Reset = 1'b0;
    cmp_en = 1'b1;

    // Program 1, Start high 3 cycles, halt on RUN cycle 25
    launch(3);
    chk("p1_idx", bus.ProgIdx, 1);
    chk("p1_done_low", bus.Done, 0);
    wait_load(0);
    run(0, 25, 1'b1, -1, 1'b0);
    chk("p1_done", bus.Done, 1);
    chk("p1_hold", bus.PcHold, 1);
    chk("p1_cnt", bus.CycleCount, 25);
    chk("p1_to", bus.Timeout, 0);
    chk("p1_flt", bus.Fault, 0);

    // Program 2, one-cycle pulse, PC jumps to 200 -> fault
    launch(1);
    chk("p2_done_clr", bus.Done, 0);
    chk("p2_idx", bus.ProgIdx, 2);
    wait_load(100);
    run(100, 1, 1'b0, 200, 1'b0);
    chk("p2_done", bus.Done, 1);
    chk("p2_flt", bus.Fault, 1);
    chk("p2_cnt", bus.CycleCount, 1);

    // Program 3, never halts, PC stays in range -> watchdog
    launch(2);
    chk("p3_idx", bus.ProgIdx, 3);
    chk("p3_flt_clr", bus.Fault, 0);
    wait_load(200);
    run(200, 4096, 1'b0, -1, 1'b0);
    chk("p3_done", bus.Done, 1);
    chk("p3_to", bus.Timeout, 1);
    chk("p3_cnt", bus.CycleCount, 4096);
    chk("p3_flt", bus.Fault, 0);

    // Fourth launch wraps to program 1
    launch(1);
    chk("p4_idx", bus.ProgIdx, 1);
    chk("p4_to_clr", bus.Timeout, 0);
    wait_load(0);
    run(0, 5, 1'b1, -1, 1'b0);
    chk("p4_cnt", bus.CycleCount, 5);

    // Program 2 again: out-of-range PC and Halt together, Halt wins
    launch(1);
    wait_load(100);
    run(100, 1, 1'b1, 200, 1'b0);
    chk("hw_done", bus.Done, 1);
    chk("hw_flt", bus.Fault, 0);

    // Program 3 with Start toggling while running, then async reset mid-RUN
    launch(1);
    wait_load(200);
    run(200, 30, 1'b0, -1, 1'b1);
    chk("tog_running", bus.PcHold, 0);
    chk("tog_done", bus.Done, 0);
    chk("tog_idx", bus.ProgIdx, 3);
    bus.Start = 1'b0;
    #3 Reset = 1'b1;
    #1;
    chk("arst_hold", bus.PcHold, 1);
    chk("arst_done", bus.Done, 0);
    chk("arst_idx", bus.ProgIdx, 0);
    chk("arst_cnt", bus.CycleCount, 0);
    @(negedge Clk); #1 Reset = 1'b0;

    // Halt pulses while idle are ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk); #1 bus.Halt = i[0];
    end
    @(negedge Clk); #1 bus.Halt = 1'b0;
    chk("idle_idx", bus.ProgIdx, 0);
    chk("idle_done", bus.Done, 0);

    // Next launch after reset is program 1 again
    launch(1);
    chk("post_idx", bus.ProgIdx, 1);
    wait_load(0);
    run(0, 3, 1'b1, -1, 1'b0);
    chk("post_cnt", bus.CycleCount, 3);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
- Run controller that sequences the program counter through the test-bench program series.
- Detects Start pulses and selects the base address of the next program. Issues a one-cycle PC load, releases the PC to run, then freezes it and raises Done on a halt, watchdog timeout or out-of-range fetch.
- Sits between the bench handshake (Start/Done) and the PC's hold/load controls.

Parameters:
- A, 10, instruction-memory address width.
- NUM_PROGS, 3, number of programs in the series.
- PROG_STRIDE, 100, address spacing between program bases (base = (ProgIdx-1)*PROG_STRIDE).
- CW, 16, cycle-counter width.
- MAX_CYCLES, 4096, watchdog limit in RUN cycles (must be <= 2^CW).

Ports:
- Clk, input, 1, clock; all state changes on posedge.
- Reset, input, 1, asynchronous active-high reset.
- Start, input, 1, bench request; a program launches on its falling edge.
- Halt, input, 1, decoder flag: current instruction is the halt/done instruction.
- ProgCtr, input, A, current PC value, used for the range check.
- PcHold, output, 1, freeze the PC (no increment or branch).
- PcLoadEn, output, 1, force the PC to PcLoadVal on the next edge; has priority over PcHold.
- PcLoadVal, output, A, base address of the selected program.
- Done, output, 1, program finished; level, held until the next Start rising edge.
- Timeout, output, 1, the last run ended by watchdog.
- Fault, output, 1, the last run ended by an out-of-range PC.
- ProgIdx, output, 2, current program number, 1..NUM_PROGS; 0 before the first Start.
- CycleCount, output, CW, RUN cycles of the current or last program.

Behaviour:
- Async reset values: state IDLE, PcHold=1, PcLoadEn=0, PcLoadVal=0, Done=0, Timeout=0, Fault=0, ProgIdx=0, CycleCount=0, start_r=0.
- start_r is a registered copy of Start.
  - Rising edge = Start & ~start_r.
  - Falling edge = ~Start & start_r.
  - Both are evaluated at a clock edge.
- States: IDLE, ARMED, LOAD, RUN, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE/DONE, on rising edge -> ARMED:
  - ProgIdx increments, wrapping NUM_PROGS -> 1.
  - Done, Timeout and Fault clear.
  - CycleCount clears.
- ARMED:
  - PcHold=1.
  - Start held high indefinitely stays in ARMED.
  - On falling edge -> LOAD.
- LOAD (exactly 1 cycle):
  - PcLoadEn=1, PcLoadVal=(ProgIdx-1)*PROG_STRIDE, computed at A bits.
  - Next state RUN unconditionally.
- RUN:
  - PcHold=0, PcLoadEn=0.
  - CycleCount increments every cycle, saturating at all-ones.
  - The first RUN cycle fetches from the base address.
- RUN exit conditions, in priority order (highest first):
  1. Halt=1 -> DONE.
  2. ProgCtr outside [base, base+PROG_STRIDE-1] -> DONE with Fault=1.
  3. CycleCount == MAX_CYCLES-1 -> DONE with Timeout=1.
  - Only the highest-priority flag is set; CycleCount still counts the exit cycle.
- DONE: PcHold=1, Done=1; Timeout, Fault and CycleCount are held.
- Ignored events:
  - Halt outside RUN.
  - Start edges in ARMED (the rising edge is already consumed), LOAD and RUN.
  - The range check in LOAD (PC not yet valid).
- Rising and falling edges cannot occur in the same cycle. A 1-cycle Start pulse gives a rising edge on cycle N (-> ARMED) and a falling edge on cycle N+1 (-> LOAD).
- Latency: Start falling edge sampled at edge E -> PcLoadEn high after E -> PC = base after E+1 -> RUN begins after E+1.
- Reset asserted mid-RUN immediately returns all outputs to reset values (PcHold=1). ProgIdx restarts at 0, so the next launch is program 1.

Test Plan:
- Reset, then Start 0->1->0 (high 3 cycles): ProgIdx=1; PcLoadEn=1 for exactly one cycle with PcLoadVal=0; PcHold=0 from the following cycle; Done=0.
- Program 1 running, Halt at 25th RUN cycle: Done=1, PcHold=1, CycleCount=25, Timeout=0, Fault=0. Second Start pulse: Done clears on the rising edge, ProgIdx=2, PcLoadVal=100.
- Three launches, then a fourth: PcLoadVal sequence 0, 100, 200; the fourth launch wraps to ProgIdx=1, PcLoadVal=0.
- RUN with Halt never asserted, PC kept in range: DONE after exactly 4096 RUN cycles, Timeout=1, CycleCount=4096 (CW=16).
- Program 2 with ProgCtr driven to 200: next cycle DONE, Fault=1. Repeat with ProgCtr=200 and Halt=1 in the same cycle: Fault=0, Done=1 (Halt wins).
- Reset pulsed asynchronously mid-RUN (between edges): PcHold=1 and Done=0 immediately, ProgIdx=0. Halt pulses in IDLE and Start toggling during RUN: no state change.
